spi_ctrl_sequencer: RTL and testbench

Host-side controller that turns parallel memory commands into serial frames for the SPI-attached RAM slave. It drives SS_n, MOSI and the serial clock domain's framing, and collects read data from MISO. It sits between a host/CPU command port and the SPI bus, and owns all frame timing: select, shift, commit hold, read-back capture and deselect gap.

---
 rtl/spi_ctrl_sequencer.sv | 215 +++++++++++++++++++++
 tb/tb_spi_ctrl_sequencer.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// spi_ctrl_sequencer
//
// Host-side SPI frame sequencer for an SPI-attached RAM slave. It accepts one
// parallel command at a time and produces the complete frame: select setup,
// MSB-first shift of {lead 0, op[1:0], payload}, then either a commit hold
// (ops 00/01/10) or a read-latency wait plus MISO capture (op 11). Every frame
// ends with a deselect gap.
//
// Optional feature macro: SPI_CTRL_RSP_HOLD_EN
//   defined   : adds input rsp_ready. rsp_valid is held until it is accepted,
//               and the sequencer waits in GAP while a response is pending.
//   undefined : no rsp_ready port. rsp_valid is a one-cycle pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   cmd_valid    host command valid
//   cmd_ready    command accepted when high together with cmd_valid
//   cmd_op       00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_payload  address/data; ignored for op 11 (sent as zeros)
//   rsp_valid    read data valid
//   rsp_data     captured read data (MSB first from MISO)
//   busy         sequencer is not idle
//   SS_n         slave select, active low, registered
//   MOSI         serial data to slave, registered
//   MISO         serial data from slave
//   rsp_ready    (SPI_CTRL_RSP_HOLD_EN only) host accepts the response
//
// All timing parameters must be >= 1 and PAYLOAD_W >= 2.
// -----------------------------------------------------------------------------
module spi_ctrl_sequencer #(
    parameter int PAYLOAD_W      = 8,
    parameter int SETUP_CYCLES   = 1,
    parameter int WR_HOLD_CYCLES = 2,
    parameter int RD_LATENCY     = 3,
    parameter int GAP_CYCLES     = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [PAYLOAD_W-1:0] cmd_payload,
    output logic                 rsp_valid,
    output logic [PAYLOAD_W-1:0] rsp_data,
    output logic                 busy,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO
`ifdef SPI_CTRL_RSP_HOLD_EN
    ,
    input  logic                 rsp_ready
`endif
);

    localparam int FRAME_W = PAYLOAD_W + 3;

    // Largest number of cycles any single state has to count.
    function automatic int cnt_max();
        int m;
        m = SETUP_CYCLES;
        if (FRAME_W > m)        m = FRAME_W;
        if (WR_HOLD_CYCLES > m) m = WR_HOLD_CYCLES;
        if (RD_LATENCY > m)     m = RD_LATENCY;
        if (PAYLOAD_W > m)      m = PAYLOAD_W;
        if (GAP_CYCLES > m)     m = GAP_CYCLES;
        return m;
    endfunction

    localparam int CNT_W = $clog2(cnt_max() + 1);

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(WR_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDW_LAST   = CNT_W'(RD_LATENCY - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(PAYLOAD_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SHIFT,
        HOLD,
        RD_WAIT,
        CAPTURE,
        GAP
    } state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [FRAME_W-1:0] frame_reg;
    logic               rd_op_reg;
    logic               gap_stall;

    // Gated by rst_n so the host never sees a ready port while reset is held.
    assign cmd_ready = rst_n && (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);

`ifdef SPI_CTRL_RSP_HOLD_EN
    // A response still waiting for the host keeps the bus in GAP.
    assign gap_stall = rsp_valid && !rsp_ready;
`else
    assign gap_stall = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            frame_reg <= '0;
            rd_op_reg <= 1'b0;
            SS_n      <= 1'b1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
`ifdef SPI_CTRL_RSP_HOLD_EN
            if (rsp_valid && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
`else
            rsp_valid <= 1'b0;
`endif
            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        // Read-data frames carry an all-zero payload field.
                        frame_reg <= {1'b0, cmd_op,
                                      (cmd_op == 2'b11) ? {PAYLOAD_W{1'b0}} : cmd_payload};
                        rd_op_reg <= (cmd_op == 2'b11);
                        cnt_reg   <= '0;
                        SS_n      <= 1'b0;
                        state_reg <= SELECT;
                    end
                end

                SELECT: begin
                    if (cnt_reg == SETUP_LAST) begin
                        // First frame bit is launched on the edge leaving SELECT.
                        MOSI      <= frame_reg[FRAME_W-1];
                        frame_reg <= {frame_reg[FRAME_W-2:0], 1'b0};
                        cnt_reg   <= '0;
                        state_reg <= SHIFT;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                SHIFT: begin
                    if (cnt_reg == SHIFT_LAST) begin
                        MOSI      <= 1'b0;
                        cnt_reg   <= '0;
                        state_reg <= rd_op_reg ? RD_WAIT : HOLD;
                    end else begin
                        MOSI      <= frame_reg[FRAME_W-1];
                        frame_reg <= {frame_reg[FRAME_W-2:0], 1'b0};
                        cnt_reg   <= cnt_reg + 1'b1;
                    end
                end

                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        SS_n      <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                RD_WAIT: begin
                    if (cnt_reg == RDW_LAST) begin
                        cnt_reg   <= '0;
                        state_reg <= CAPTURE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                CAPTURE: begin
                    rsp_data <= {rsp_data[PAYLOAD_W-2:0], MISO};
                    if (cnt_reg == CAP_LAST) begin
                        rsp_valid <= 1'b1;
                        SS_n      <= 1'b1;
                        cnt_reg   <= '0;
                        state_reg <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        // Counter parks at its last value while stalled.
                        if (!gap_stall) begin
                            cnt_reg   <= '0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    SS_n      <= 1'b1;
                    MOSI      <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_ctrl_sequencer.sv
// -----------------------------------------------------------------------------
// tb_spi_ctrl_sequencer
//
// Self-checking bench for spi_ctrl_sequencer at default parameters. A slave
// model decodes the op from MOSI and returns a byte on MISO for read-data
// frames. Each transaction is checked cycle by cycle against a timeline
// derived from the frame rules (setup, frame bits, hold or latency+capture,
// gap). Hand-written vectors come from a table; random commands follow.
// -----------------------------------------------------------------------------
module tb_spi_ctrl_sequencer;

    localparam int W        = 8;
    localparam int SETUP    = 1;
    localparam int WHOLD    = 2;
    localparam int RDL      = 3;
    localparam int GAPC     = 2;
    localparam int F        = W + 3;
    localparam int RD_START = SETUP + F + RDL;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_payload = '0;
    logic         rsp_valid;
    logic [W-1:0] rsp_data;
    logic         busy;
    logic         SS_n;
    logic         MOSI;
    logic         MISO = 1'b0;
`ifdef SPI_CTRL_RSP_HOLD_EN
    logic         rsp_ready = 1'b1;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spi_ctrl_sequencer #(
        .PAYLOAD_W      (W),
        .SETUP_CYCLES   (SETUP),
        .WR_HOLD_CYCLES (WHOLD),
        .RD_LATENCY     (RDL),
        .GAP_CYCLES     (GAPC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_payload (cmd_payload),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .SS_n        (SS_n),
        .MOSI        (MOSI),
        .MISO        (MISO)
`ifdef SPI_CTRL_RSP_HOLD_EN
        ,
        .rsp_ready   (rsp_ready)
`endif
    );

    // Slave model: counts selected cycles, decodes op from the received
    // frame bits and returns slv_data MSB first once the read latency expires.
    logic [W-1:0] slv_data = '0;
    logic [1:0]   slv_op = 2'b00;
    int           slv_k = 0;

    always @(negedge clk) begin
        if (SS_n !== 1'b0) begin
            slv_k  = 0;
            slv_op = 2'b00;
            MISO   = 1'b0;
        end else begin
            if (slv_k == SETUP + 1) slv_op[1] = MOSI;
            if (slv_k == SETUP + 2) slv_op[0] = MOSI;
            if (slv_op == 2'b11 && slv_k >= RD_START && slv_k < RD_START + W)
                MISO = slv_data[W-1-(slv_k-RD_START)];
            else
                MISO = 1'b0;
            slv_k++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int t = 0;
        while (cmd_ready !== 1'b1 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", cmd_ready, 1);
    endtask

    // Issue one command and check every cycle of its frame and gap.
    task automatic run_cmd(input logic [1:0] op, input logic [W-1:0] payload,
                           input logic [W-1:0] miso_byte, input bit hold,
                           input int exp_len, input logic [F-1:0] exp_frame,
                           input logic [W-1:0] exp_rsp, input string name);
        logic exp_mosi;
        slv_data = miso_byte;
        wait_ready();
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_payload = payload;
        @(posedge clk);
        for (int k = 0; k <= exp_len + GAPC; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) cmd_valid = 1'b0;
            if (hold && k < exp_len + GAPC) begin
                // Command-port traffic during a frame must be ignored.
                cmd_op      = 2'($urandom);
                cmd_payload = W'($urandom);
            end
            if (k >= SETUP && k < SETUP + F) exp_mosi = exp_frame[F-1-(k-SETUP)];
            else                             exp_mosi = 1'b0;
            chk({name, "_ss"},    SS_n, (k < exp_len) ? 0 : 1);
            chk({name, "_mosi"},  MOSI, exp_mosi);
            chk({name, "_rv"},    rsp_valid, (op == 2'b11 && k == exp_len) ? 1 : 0);
            chk({name, "_busy"},  busy, (k < exp_len + GAPC) ? 1 : 0);
            chk({name, "_ready"}, cmd_ready, (k == exp_len + GAPC) ? 1 : 0);
            if (op == 2'b11 && k == exp_len) chk({name, "_rdata"}, rsp_data, exp_rsp);
        end
        $display("txn %s op=%0d payload=%02h len=%0d rsp=%02h", name, op, payload, exp_len, rsp_data);
    endtask

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] payload;
        logic [W-1:0] miso;
        bit           hold;
        int           exp_len;
        logic [F-1:0] exp_frame;
        logic [W-1:0] exp_rsp;
    } vec_t;

    vec_t vecs[7];

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [1:0]   r_op;
        logic [W-1:0] r_pl, r_miso;
        bit           r_hold, seen;
        int           r_len;

        vecs[0] = '{2'b00, 8'hA5, 8'h00, 1'b0, 14, 11'b000_1010_0101, 8'h00};
        vecs[1] = '{2'b00, 8'h12, 8'h00, 1'b1, 14, 11'b000_0001_0010, 8'h00};
        vecs[2] = '{2'b01, 8'h3C, 8'h00, 1'b1, 14, 11'b001_0011_1100, 8'h00};
        vecs[3] = '{2'b11, 8'hFF, 8'hC3, 1'b0, 23, 11'b011_0000_0000, 8'hC3};
        vecs[4] = '{2'b10, 8'h81, 8'h00, 1'b0, 14, 11'b010_1000_0001, 8'h00};
        vecs[5] = '{2'b11, 8'h55, 8'h01, 1'b1, 23, 11'b011_0000_0000, 8'h01};
        vecs[6] = '{2'b10, 8'h7E, 8'h00, 1'b0, 14, 11'b010_0111_1110, 8'h00};

        // Reset with a command pending.
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_ss",    SS_n, 1);
        chk("rst_mosi",  MOSI, 0);
        chk("rst_ready", cmd_ready, 0);
        chk("rst_rv",    rsp_valid, 0);
        chk("rst_busy",  busy, 0);
        chk("rst_rdata", rsp_data, 0);
        rst_n = 1'b1;
        #1;
        chk("rel_ready", cmd_ready, 1);
        cmd_valid = 1'b0;
        @(negedge clk);

        foreach (vecs[i])
            run_cmd(vecs[i].op, vecs[i].payload, vecs[i].miso, vecs[i].hold,
                    vecs[i].exp_len, vecs[i].exp_frame, vecs[i].exp_rsp,
                    $sformatf("vec%0d", i));
        chk("rdata_held", rsp_data, 8'h01);

        // Asynchronous reset in the middle of a read-data frame.
        slv_data = 8'hFF;
        wait_ready();
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_ss",    SS_n, 1);
        chk("arst_mosi",  MOSI, 0);
        chk("arst_busy",  busy, 0);
        chk("arst_ready", cmd_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || SS_n !== 1'b1) seen = 1'b1;
        end
        chk("arst_no_rsp", seen, 0);
        chk("arst_rdata",  rsp_data, 0);
        run_cmd(2'b11, 8'h00, 8'h96, 1'b0, 23, 11'b011_0000_0000, 8'h96, "post_rst");

        // Random commands against the frame-rule model.
        for (int i = 0; i < 40; i++) begin
            r_op   = 2'($urandom_range(0, 3));
            r_pl   = W'($urandom);
            r_miso = W'($urandom);
            r_hold = (i < 39) ? 1'($urandom_range(0, 1)) : 1'b0;
            r_len  = (r_op == 2'b11) ? SETUP + F + RDL + W : SETUP + F + WHOLD;
            run_cmd(r_op, r_pl, r_miso, r_hold, r_len,
                    {1'b0, r_op, (r_op == 2'b11) ? {W{1'b0}} : r_pl}, r_miso,
                    $sformatf("rnd%0d", i));
        end

`ifdef SPI_CTRL_RSP_HOLD_EN
        begin : hold_test
            int  t;
            bit  bad;
            slv_data  = 8'h5A;
            rsp_ready = 1'b0;
            wait_ready();
            cmd_valid = 1'b1;
            cmd_op    = 2'b11;
            @(posedge clk);
            @(negedge clk);
            cmd_valid = 1'b0;
            t = 0;
            while (rsp_valid !== 1'b1 && t < 60) begin
                @(negedge clk);
                t++;
            end
            chk("hold_rise", rsp_valid, 1);
            chk("hold_data", rsp_data, 8'h5A);
            bad = 1'b0;
            repeat (10) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || SS_n !== 1'b1) bad = 1'b1;
            end
            chk("hold_stall", bad, 0);
            rsp_ready = 1'b1;
            @(negedge clk);
            chk("hold_clear", rsp_valid, 0);
            chk("hold_ready", cmd_ready, 1);
            $display("txn hold op=3 rsp=%02h", rsp_data);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
